n8_bcd_b2_converter: RTL
========================

# n8_bcd_b2_converter

Sequential BCD-to-binary converter: takes three BCD digits (hundreds, tens, units) and produces their 8-bit binary value using reverse double-dabble (shift right, subtract 3 from any digit ≥ 8), one bit per two clock cycles. It is the inverse of the binary-to-BCD converter and sits on the input side of the datapath, e.g. turning keypad or display-register BCD values into binary operands. A soc/eoc handshake frames each conversion; overflow (value > 255) and invalid-digit conditions are flagged.

## Interface
- No parameters; widths are fixed (3 BCD digits in, 8 bits out).
- clock  in  1  single system clock; all state changes on posedge.
- reset_  in  1  reset is synchronous and active-low.
- soc  in  1  start of conversion; sampled in IDLE.
- a3_a0  in  4  hundreds digit; sampled on the start edge only.
- b3_b0  in  4  tens digit; sampled on the start edge only.
- c3_c0  in  4  units digit; sampled on the start edge only.
- x7_x0  out  8  binary result (value mod 256); registered.
- ovf  out  1  1 if the BCD value > 255; registered.
- err  out  1  1 if any input digit > 9; registered.
- eoc  out  1  end of conversion / ready; 1 in IDLE and DONE, 0 while converting.

## Operation
- 20-bit work register s19_s0 = {hundreds, tens, units, 8-bit binary field}; 3-bit COUNT; 2-bit state STAR.
- IDLE: eoc=1. If soc=1: s19_s0 ← {a3_a0, b3_b0, c3_c0, 8'h00}, COUNT ← 7, err_int ← (any digit > 9), go to SHIFT. Otherwise stay.
- SHIFT: s19_s0 ← s19_s0 >> 1 (logical, zero into bit 19); go to CORR.
- CORR: each of fields [19:16], [15:12], [11:8]: if ≥ 8, subtract 3, else unchanged; [7:0] unchanged. Corrected value written to s19_s0. If COUNT=0: go to DONE, x7_x0 ← err_int ? 0 : corrected[7:0], ovf ← err_int ? 0 : |corrected[19:8], err ← err_int. Else COUNT ← COUNT−1, go to SHIFT.
- DONE: eoc=1, outputs stable. When soc=0, go to IDLE; while soc=1, stay. A soc held high never retriggers.
- Invalid digits do not shorten the conversion; latency is uniform.
- x7_x0/ovf/err change only on the CORR→DONE edge and on reset; they hold their previous values during a new conversion.
- Arithmetic: the corrected digit is 4 bits. A field ≥ 8 minus 3 never underflows.

## Timing
- Reset: at any posedge with reset_=0: STAR ← IDLE, eoc=1, x7_x0=8'h00, ovf=0, err=0, COUNT=0, s19_s0=0. This overrides soc and aborts a conversion in progress, with no partial result.
- Edge 0 = edge where IDLE samples soc=1. On edges 1..16, SHIFT (odd) and CORR (even) alternate: 8 iterations. Edge 16 enters DONE.
- eoc falls after edge 0 and rises after edge 16. The result is valid exactly when eoc rises.
- Minimum handshake period: soc high ≥ 1 cycle; the next conversion can start 2 edges after soc falls in DONE.
- The digit inputs may change freely after edge 0.

## Structure
- The shared include holds the state codes (IDLE=2'b00, SHIFT=2'b01, CORR=2'b10, DONE=2'b11), the iteration count (8), the correction threshold (8) and the constant 3.
- Sub-module sub_3: 4-bit combinational, z3_z0 = (x3_x0 ≥ 8) ? x3_x0 − 3 : x3_x0. There are three instances, on fields [19:16], [15:12] and [11:8].
- The top module contains the FSM, COUNT, the work register and the output registers.

## Test plan
- Reset: hold reset_=0 for 2 cycles with soc=1 → x7_x0=00, ovf=0, err=0, eoc=1. No conversion starts.
- Max in range: digits 2,5,5, soc pulse → eoc low for 16 cycles, then x7_x0=FF, ovf=0, err=0.
- Typical and edge values: 1,2,8 → 80; 0,0,0 → 00; 0,1,0 → 0A; each with latency exactly 16.
- Overflow: 2,5,6 → x7_x0=00, ovf=1. 9,9,9 → x7_x0=E7, ovf=1, err=0.
- Invalid digit: 0,A,3 → after 16 cycles x7_x0=00, ovf=0, err=1.
- Handshake and abort:
  - Keep soc high through DONE: no restart. Drop soc, then raise it again: a new conversion starts.
  - Assert reset_=0 at edge 8 of a conversion: IDLE on that edge, eoc=1, outputs cleared.

Source files
------------

// File: rtl/n8_bcd_b2_converter_pkg.sv
// Shared constants and types for the 3-digit BCD to 8-bit binary converter.
package n8_bcd_b2_converter_pkg;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned NUM_DIGITS  = 3;
    localparam int unsigned BIN_W       = 8;
    localparam int unsigned WORK_W      = NUM_DIGITS * DIGIT_W + BIN_W;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned ITER_N      = 8;
    localparam int unsigned CORR_THRESH = 8;
    localparam int unsigned CORR_SUB    = 3;
    localparam int unsigned BCD_MAX     = 9;

    // Converter sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        CORR  = 2'b10,
        DONE  = 2'b11
    } star_e;

    // True when a 4-bit value is not a legal BCD digit
    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return d > DIGIT_W'(BCD_MAX);
    endfunction

endpackage

// File: rtl/n8_bcd_b2_converter_if.sv
// Conversion handshake and data bus between a requester and the converter.
interface n8_bcd_b2_converter_if;
    import n8_bcd_b2_converter_pkg::*;

    logic               soc;
    logic [DIGIT_W-1:0] a3_a0;
    logic [DIGIT_W-1:0] b3_b0;
    logic [DIGIT_W-1:0] c3_c0;
    logic [BIN_W-1:0]   x7_x0;
    logic               ovf;
    logic               err;
    logic               eoc;

    // Requester side
    modport master (
        output soc, a3_a0, b3_b0, c3_c0,
        input  x7_x0, ovf, err, eoc
    );

    // Converter side
    modport slave (
        input  soc, a3_a0, b3_b0, c3_c0,
        output x7_x0, ovf, err, eoc
    );

endinterface

// File: rtl/n8_bcd_b2_converter_sub_3.sv
// Per-digit correction step of reverse double-dabble: digits at or above 8 lose 3.
module n8_bcd_b2_converter_sub_3
    import n8_bcd_b2_converter_pkg::*;
(
    input  logic [DIGIT_W-1:0] x3_x0,
    output logic [DIGIT_W-1:0] z3_z0
);

    // A field >= 8 minus 3 stays non-negative, so no borrow handling is needed
    assign z3_z0 = (x3_x0 >= DIGIT_W'(CORR_THRESH)) ? (x3_x0 - DIGIT_W'(CORR_SUB))
                                                    : x3_x0;

endmodule

// File: rtl/n8_bcd_b2_converter.sv
// Sequential BCD-to-binary converter, one result bit per SHIFT/CORR pair.
module n8_bcd_b2_converter
    import n8_bcd_b2_converter_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset_,
    n8_bcd_b2_converter_if.slave          bus
);

    star_e              star_q;
    logic [WORK_W-1:0]  s19_s0_q;
    logic [CNT_W-1:0]   count_q;
    logic               err_int_q;
    logic [BIN_W-1:0]   x7_x0_q;
    logic               ovf_q;
    logic               err_q;
    logic               eoc_q;

    logic [WORK_W-1:0]  corr_d;
    logic               start_err_c;

    // Digit correction on the three BCD fields; binary field passes through
    n8_bcd_b2_converter_sub_3 u_sub_h (
        .x3_x0 (s19_s0_q[19:16]),
        .z3_z0 (corr_d[19:16])
    );

    n8_bcd_b2_converter_sub_3 u_sub_t (
        .x3_x0 (s19_s0_q[15:12]),
        .z3_z0 (corr_d[15:12])
    );

    n8_bcd_b2_converter_sub_3 u_sub_u (
        .x3_x0 (s19_s0_q[11:8]),
        .z3_z0 (corr_d[11:8])
    );

    assign corr_d[BIN_W-1:0] = s19_s0_q[BIN_W-1:0];

    // Any illegal digit on the start edge poisons the whole conversion
    assign start_err_c = digit_invalid(bus.a3_a0)
                       | digit_invalid(bus.b3_b0)
                       | digit_invalid(bus.c3_c0);

    // Sequencer, work register, iteration counter and result registers
    always_ff @(posedge clock) begin
        if (!reset_) begin
            star_q    <= IDLE;
            s19_s0_q  <= '0;
            count_q   <= '0;
            err_int_q <= 1'b0;
            x7_x0_q   <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            eoc_q     <= 1'b1;
        end else begin
            case (star_q)
                IDLE: begin
                    if (bus.soc) begin
                        s19_s0_q  <= {bus.a3_a0, bus.b3_b0, bus.c3_c0, BIN_W'(0)};
                        count_q   <= CNT_W'(ITER_N - 1);
                        err_int_q <= start_err_c;
                        eoc_q     <= 1'b0;
                        star_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    s19_s0_q <= s19_s0_q >> 1;
                    star_q   <= CORR;
                end
                CORR: begin
                    s19_s0_q <= corr_d;
                    if (count_q == '0) begin
                        x7_x0_q <= err_int_q ? BIN_W'(0) : corr_d[BIN_W-1:0];
                        ovf_q   <= err_int_q ? 1'b0 : (|corr_d[WORK_W-1:BIN_W]);
                        err_q   <= err_int_q;
                        eoc_q   <= 1'b1;
                        star_q  <= DONE;
                    end else begin
                        count_q <= count_q - CNT_W'(1);
                        star_q  <= SHIFT;
                    end
                end
                DONE: begin
                    // Wait for soc to drop so a held request cannot retrigger
                    if (!bus.soc) begin
                        star_q <= IDLE;
                    end
                end
                default: begin
                    star_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.x7_x0 = x7_x0_q;
    assign bus.ovf   = ovf_q;
    assign bus.err   = err_q;
    assign bus.eoc   = eoc_q;

endmodule
